// File: rtl/time_set_ctrl_if.sv
// Front-panel bus for time_set_ctrl: key pulses, live time and edit outputs.
// The panel/test side uses the master modport; the controller uses slave.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic       key_dec;
    logic [6:0] cur_less;
    logic [6:0] cur_middle;
    logic [6:0] cur_big;
    logic       set_clock;
    logic       set_ala;
    logic       set_cla;
    logic [6:0] Less;
    logic [6:0] Middle;
    logic [6:0] Big;
    logic [1:0] field;
    logic       blink;

    modport master (
        output tick_1hz, key_mode, key_sel, key_inc, key_dec,
        output cur_less, cur_middle, cur_big,
        input  set_clock, set_ala, set_cla, Less, Middle, Big, field, blink
    );

    modport slave (
        input  tick_1hz, key_mode, key_sel, key_inc, key_dec,
        input  cur_less, cur_middle, cur_big,
        output set_clock, set_ala, set_cla, Less, Middle, Big, field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Front-panel setting controller: walks IDLE -> CLOCK -> ALARM -> CLA -> IDLE,
// moves a field cursor and edits sec/min/hour values with modulo wrap.
// Drops back to IDLE after TIMEOUT_S quiet seconds.
// Optional macro TIME_SET_BLINK_EN adds a 1 Hz blink toggle for the edited field.
module time_set_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int HOUR_MAX  = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CLOCK, S_ALARM, S_CLA} state_t;

    localparam logic [6:0] SEC_MAX = 7'd59;
    localparam logic [6:0] BIG_MAX = 7'(HOUR_MAX);
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

    state_t     state;
    logic [5:0] idle_cnt;
    logic [6:0] less_q;
    logic [6:0] middle_q;
    logic [6:0] big_q;
    logic [1:0] field_q;
    logic       set_clock_q;
    logic       set_ala_q;
    logic       set_cla_q;

    logic       any_key;
    logic       in_edit;
    logic       expire;
    logic [6:0] sel_val;
    logic [6:0] sel_max;
    logic [6:0] new_val;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
        return (v >= max) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] max);
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

    assign any_key = bus.key_mode | bus.key_sel | bus.key_inc | bus.key_dec;
    assign in_edit = (state != S_IDLE);
    // A coincident key cancels the expiring tick, hence !any_key here.
    assign expire  = in_edit && bus.tick_1hz && !any_key && (idle_cnt == TO_LAST);

    // Pick the value and range of the field under the cursor and form its edited value.
    always_comb begin
        sel_val = big_q;
        sel_max = BIG_MAX;
        case (field_q)
            2'd0:    begin sel_val = less_q;   sel_max = SEC_MAX; end
            2'd1:    begin sel_val = middle_q; sel_max = SEC_MAX; end
            default: begin sel_val = big_q;    sel_max = BIG_MAX; end
        endcase
        new_val = bus.key_inc ? wrap_inc(sel_val, sel_max) : wrap_dec(sel_val, sel_max);
    end

    // Mode FSM with registered select levels, edit values, cursor and inactivity counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idle_cnt    <= 6'd0;
            less_q      <= 7'd0;
            middle_q    <= 7'd0;
            big_q       <= 7'd0;
            field_q     <= 2'd0;
            set_clock_q <= 1'b0;
            set_ala_q   <= 1'b0;
            set_cla_q   <= 1'b0;
        end else if (bus.key_mode) begin
            field_q  <= 2'd0;
            idle_cnt <= 6'd0;
            case (state)
                S_IDLE: begin
                    state <= S_CLOCK;
                    {set_clock_q, set_ala_q, set_cla_q} <= 3'b100;
                    less_q   <= bus.cur_less;
                    middle_q <= bus.cur_middle;
                    big_q    <= bus.cur_big;
                end
                S_CLOCK: begin
                    state <= S_ALARM;
                    {set_clock_q, set_ala_q, set_cla_q} <= 3'b010;
                    less_q   <= 7'd0;
                    middle_q <= 7'd0;
                    big_q    <= 7'd0;
                end
                S_ALARM: begin
                    state <= S_CLA;
                    {set_clock_q, set_ala_q, set_cla_q} <= 3'b001;
                    less_q   <= 7'd0;
                    middle_q <= 7'd0;
                    big_q    <= 7'd0;
                end
                default: begin
                    state <= S_IDLE;
                    {set_clock_q, set_ala_q, set_cla_q} <= 3'b000;
                end
            endcase
        end else if (in_edit) begin
            if (any_key) begin
                idle_cnt <= 6'd0;
                if (bus.key_sel) begin
                    field_q <= (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                end else begin
                    case (field_q)
                        2'd0:    less_q   <= new_val;
                        2'd1:    middle_q <= new_val;
                        default: big_q    <= new_val;
                    endcase
                end
            end else if (expire) begin
                state    <= S_IDLE;
                {set_clock_q, set_ala_q, set_cla_q} <= 3'b000;
                field_q  <= 2'd0;
                idle_cnt <= 6'd0;
            end else if (bus.tick_1hz) begin
                idle_cnt <= idle_cnt + 6'd1;
            end
        end
    end

    assign bus.set_clock = set_clock_q;
    assign bus.set_ala   = set_ala_q;
    assign bus.set_cla   = set_cla_q;
    assign bus.Less      = less_q;
    assign bus.Middle    = middle_q;
    assign bus.Big       = big_q;
    assign bus.field     = field_q;

`ifdef TIME_SET_BLINK_EN
    logic toggle_q;

    // Blink toggles each second while editing; any key or leaving edit forces it visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else if (any_key || !in_edit || expire) begin
            toggle_q <= 1'b0;
        end else if (bus.tick_1hz) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign bus.blink = toggle_q;
`else
    assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl (TIMEOUT_S=3, HOUR_MAX=23).
// Expected blink values follow TIME_SET_BLINK_EN when it is defined.
module tb_time_set_ctrl;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_MODE = 5'b10000;
    localparam logic [4:0] K_SEL  = 5'b01000;
    localparam logic [4:0] K_INC  = 5'b00100;
    localparam logic [4:0] K_DEC  = 5'b00010;
    localparam logic [4:0] K_TICK = 5'b00001;

`ifdef TIME_SET_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .TIMEOUT_S (3),
        .HOUR_MAX  (23)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bl(input logic x);
        return BLINK_EN & x;
    endfunction

    // Drive one cycle of key/tick pulses, then release them just after the edge.
    task automatic applyStimulus(input logic [4:0] keys);
        @(negedge clk);
        {bus.key_mode, bus.key_sel, bus.key_inc, bus.key_dec, bus.tick_1hz} = keys;
        @(posedge clk);
        #1;
        {bus.key_mode, bus.key_sel, bus.key_inc, bus.key_dec, bus.tick_1hz} = K_NONE;
    endtask

    // Compare every output against hand-computed expectations.
    task automatic checkOutput(input string tag, input logic [2:0] e_set,
                               input logic [6:0] e_l, input logic [6:0] e_m,
                               input logic [6:0] e_b, input logic [1:0] e_f,
                               input logic e_blink);
        logic [26:0] obs;
        logic [26:0] exp_v;
        obs   = {bus.set_clock, bus.set_ala, bus.set_cla, bus.Less, bus.Middle,
                 bus.Big, bus.field, bus.blink};
        exp_v = {e_set, e_l, e_m, e_b, e_f, e_blink};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed set=%b L=%0d M=%0d B=%0d f=%0d blink=%b, expected set=%b L=%0d M=%0d B=%0d f=%0d blink=%b",
                   tag, obs[26:24], obs[23:17], obs[16:10], obs[9:3], obs[2:1], obs[0],
                   e_set, e_l, e_m, e_b, e_f, e_blink);
        end
    endtask

    // Linear directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        {bus.key_mode, bus.key_sel, bus.key_inc, bus.key_dec, bus.tick_1hz} = K_NONE;
        bus.cur_less   = 7'd0;
        bus.cur_middle = 7'd0;
        bus.cur_big    = 7'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 3'b000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        $display("[TB] mode walk and entry loads");
        bus.cur_less   = 7'd45;
        bus.cur_middle = 7'd30;
        bus.cur_big    = 7'd12;
        applyStimulus(K_MODE);         checkOutput("enter_clock", 3'b100, 45, 30, 12, 0, 0);
        applyStimulus(K_MODE);         checkOutput("enter_alarm", 3'b010, 0, 0, 0, 0, 0);
        applyStimulus(K_MODE);         checkOutput("enter_cla", 3'b001, 0, 0, 0, 0, 0);
        applyStimulus(K_MODE);         checkOutput("exit_idle", 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(K_INC);          checkOutput("idle_inc_ignored", 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(K_SEL);          checkOutput("idle_sel_ignored", 3'b000, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(K_TICK);
        checkOutput("idle_no_timeout", 3'b000, 0, 0, 0, 0, 0);

        $display("[TB] field editing and wrap");
        applyStimulus(K_MODE);         checkOutput("reenter_clock", 3'b100, 45, 30, 12, 0, 0);
        applyStimulus(K_INC);          checkOutput("clock_inc_less", 3'b100, 46, 30, 12, 0, 0);
        applyStimulus(K_MODE);         checkOutput("alarm_zero", 3'b010, 0, 0, 0, 0, 0);
        applyStimulus(K_SEL);          checkOutput("alarm_sel1", 3'b010, 0, 0, 0, 1, 0);
        applyStimulus(K_DEC);          checkOutput("middle_dec_wrap", 3'b010, 0, 59, 0, 1, 0);
        applyStimulus(K_INC);          checkOutput("middle_inc_wrap", 3'b010, 0, 0, 0, 1, 0);
        applyStimulus(K_SEL);          checkOutput("alarm_sel2", 3'b010, 0, 0, 0, 2, 0);
        applyStimulus(K_DEC);          checkOutput("big_dec_wrap", 3'b010, 0, 0, 23, 2, 0);
        applyStimulus(K_INC);          checkOutput("big_inc_wrap", 3'b010, 0, 0, 0, 2, 0);
        applyStimulus(K_SEL);          checkOutput("sel_wrap", 3'b010, 0, 0, 0, 0, 0);
        applyStimulus(K_DEC);          checkOutput("less_dec_wrap", 3'b010, 59, 0, 0, 0, 0);
        applyStimulus(K_SEL | K_INC);  checkOutput("sel_beats_inc", 3'b010, 59, 0, 0, 1, 0);
        applyStimulus(K_INC | K_DEC);  checkOutput("inc_beats_dec", 3'b010, 59, 1, 0, 1, 0);

        $display("[TB] timeout");
        applyStimulus(K_MODE);         checkOutput("alarm_to_cla", 3'b001, 0, 0, 0, 0, 0);
        applyStimulus(K_TICK);         checkOutput("cla_tick1", 3'b001, 0, 0, 0, 0, bl(1));
        applyStimulus(K_TICK);         checkOutput("cla_tick2", 3'b001, 0, 0, 0, 0, 0);
        applyStimulus(K_TICK);         checkOutput("cla_timeout", 3'b000, 0, 0, 0, 0, 0);

        bus.cur_less   = 7'd10;
        bus.cur_middle = 7'd20;
        bus.cur_big    = 7'd5;
        applyStimulus(K_MODE);         checkOutput("clock_load2", 3'b100, 10, 20, 5, 0, 0);
        applyStimulus(K_MODE | K_INC); checkOutput("mode_beats_inc", 3'b010, 0, 0, 0, 0, 0);
        applyStimulus(K_MODE);         checkOutput("cla_again", 3'b001, 0, 0, 0, 0, 0);
        applyStimulus(K_TICK);
        applyStimulus(K_TICK);
        applyStimulus(K_TICK | K_INC); checkOutput("tick_key_cancel", 3'b001, 1, 0, 0, 0, 0);
        applyStimulus(K_TICK);         checkOutput("cnt_cleared1", 3'b001, 1, 0, 0, 0, bl(1));
        applyStimulus(K_TICK);         checkOutput("cnt_cleared2", 3'b001, 1, 0, 0, 0, 0);
        applyStimulus(K_TICK);         checkOutput("timeout_hold", 3'b000, 1, 0, 0, 0, 0);

        $display("[TB] blink");
        applyStimulus(K_MODE);         checkOutput("clock_load3", 3'b100, 10, 20, 5, 0, 0);
        applyStimulus(K_TICK);         checkOutput("blink_on", 3'b100, 10, 20, 5, 0, bl(1));
        applyStimulus(K_INC);          checkOutput("blink_key_clear", 3'b100, 11, 20, 5, 0, 0);
        applyStimulus(K_TICK);         checkOutput("blink_on2", 3'b100, 11, 20, 5, 0, bl(1));
        applyStimulus(K_TICK);         checkOutput("blink_off", 3'b100, 11, 20, 5, 0, 0);

        $display("[TB] reset mid-edit");
        applyStimulus(K_MODE);         checkOutput("alarm_again", 3'b010, 0, 0, 0, 0, 0);
        applyStimulus(K_SEL);
        applyStimulus(K_SEL);
        repeat (7) applyStimulus(K_INC);
        checkOutput("alarm_big7", 3'b010, 0, 0, 7, 2, 0);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.key_inc = 1'b1;
        @(posedge clk);
        #1;
        bus.key_inc = 1'b0;
        rst_n       = 1'b1;
        checkOutput("reset_mid_edit", 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(K_NONE);         checkOutput("post_reset_idle", 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(K_MODE);         checkOutput("post_reset_clock", 3'b100, 10, 20, 5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
